alu_control_md: RTL and testbench



---
 rtl/alu_control_md_if.sv | 27 ++
 rtl/alu_control_md.sv | 160 ++++++++++++++++
 tb/tb_alu_control_md.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/alu_control_md_if.sv
// Bus between the main control FSM and the ALU control / mult-div sequencer.
// The master drives decode fields, launch request and operands; the slave returns status and HI/LO.
interface alu_control_md_if #(
   parameter int WIDTH = 32
);
   logic [1:0]       ULAOp;
   logic [5:0]       funct;
   logic [2:0]       ULAOpSelector;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output ULAOp, funct, start, a, b,
      input  ULAOpSelector, busy, done, div_zero, hi, lo
   );

   modport slave (
      input  ULAOp, funct, start, a, b,
      output ULAOpSelector, busy, done, div_zero, hi, lo
   );
endinterface

// File: rtl/alu_control_md.sv
// ALU control for the multicycle MIPS core: combinational ULAOpSelector decode plus an
// iterative shift-add multiplier / restoring divider that writes HI/LO.
module alu_control_md #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input logic              clk,
   input logic              reset_n,
   alu_control_md_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] work;
   logic [2*WIDTH-1:0] work_next;
   logic [WIDTH-1:0]   opnd;
   logic               is_div;
   logic               neg_q;
   logic               neg_r;
   logic               busy_q;
   logic               done_q;
   logic               div_zero_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;

   logic               is_md;
   logic               launch;
   logic               launch_div;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     shifted;
   logic [WIDTH:0]     diff;
   logic [2*WIDTH-1:0] mul_res;
   logic [WIDTH-1:0]   quo_res;
   logic [WIDTH-1:0]   rem_res;

   always_comb begin
      bus.ULAOpSelector = 3'b001;
      case (bus.ULAOp)
         2'b00: bus.ULAOpSelector = 3'b001;
         2'b01: bus.ULAOpSelector = 3'b010;
         2'b10: begin
            case (bus.funct)
               6'h20:   bus.ULAOpSelector = 3'b001;
               6'h22:   bus.ULAOpSelector = 3'b010;
               6'h24:   bus.ULAOpSelector = 3'b011;
               6'h26:   bus.ULAOpSelector = 3'b110;
               6'h2A:   bus.ULAOpSelector = 3'b111;
               default: bus.ULAOpSelector = 3'b001;
            endcase
         end
         default: bus.ULAOpSelector = 3'b000;
      endcase
   end

   // funct 0x18..0x1B: bit 1 selects divide, bit 0 selects the unsigned variant.
   // DONE also accepts a launch so back-to-back operations cost WIDTH+1 cycles.
   assign is_md      = (bus.ULAOp == 2'b10) && (bus.funct[5:2] == 4'b0110);
   assign launch     = bus.start && is_md && (state == IDLE || state == DONE);
   assign launch_div = bus.funct[1];
   assign a_neg      = ~bus.funct[0] & bus.a[WIDTH-1];
   assign b_neg      = ~bus.funct[0] & bus.b[WIDTH-1];
   assign a_mag      = a_neg ? -bus.a : bus.a;
   assign b_mag      = b_neg ? -bus.b : bus.b;

   // One iteration: shift-add keeps the product in work; restoring divide keeps
   // remainder in the upper half and dividend/quotient bits in the lower half.
   always_comb begin
      work_next = work;
      sum       = '0;
      shifted   = '0;
      diff      = '0;
      if (is_div) begin
         shifted = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
         diff    = shifted - {1'b0, opnd};
         if (!diff[WIDTH])
            work_next = {diff[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
         else
            work_next = {shifted[WIDTH-1:0], work[WIDTH-2:0], 1'b0};
      end else begin
         sum       = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
         work_next = {sum, work[WIDTH-1:1]};
      end
   end

   assign mul_res = neg_q ? -work_next : work_next;
   assign quo_res = neg_q ? -work_next[WIDTH-1:0] : work_next[WIDTH-1:0];
   assign rem_res = neg_r ? -work_next[2*WIDTH-1:WIDTH] : work_next[2*WIDTH-1:WIDTH];

   // Sequencer FSM; status outputs and HI/LO are registered here.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         cnt        <= '0;
         work       <= '0;
         opnd       <= '0;
         is_div     <= 1'b0;
         neg_q      <= 1'b0;
         neg_r      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               state      <= IDLE;
               done_q     <= 1'b0;
               div_zero_q <= 1'b0;
               if (launch) begin
                  is_div <= launch_div;
                  neg_q  <= a_neg ^ b_neg;
                  neg_r  <= a_neg;
                  opnd   <= launch_div ? b_mag : a_mag;
                  work   <= {{WIDTH{1'b0}}, (launch_div ? a_mag : b_mag)};
                  if (launch_div && bus.b == '0) begin
                     state      <= DONE;
                     done_q     <= 1'b1;
                     div_zero_q <= 1'b1;
                  end else begin
                     state  <= RUN;
                     busy_q <= 1'b1;
                     cnt    <= CNT_W'(WIDTH);
                  end
               end
            end
            RUN: begin
               work <= work_next;
               cnt  <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state  <= DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  if (is_div) begin
                     hi_q <= rem_res;
                     lo_q <= quo_res;
                  end else begin
                     hi_q <= mul_res[2*WIDTH-1:WIDTH];
                     lo_q <= mul_res[WIDTH-1:0];
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.div_zero = div_zero_q;
   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;

endmodule

// File: tb/tb_alu_control_md.sv
// Directed bench for alu_control_md: selector decode, mult/div results and latency,
// divide-by-zero, handshake corner cases and asynchronous reset abort.
module tb_alu_control_md;

   logic clk;
   logic reset_n;
   int   total;
   int   bad;

   alu_control_md_if #(.WIDTH(32)) bus ();

   alu_control_md #(.WIDTH(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Launches one mult/div and follows it to completion; optionally pulses start
   // with different operands mid-run, which must be ignored.
   task automatic apply_stimulus(input string tag, input logic [5:0] f,
                                 input logic [31:0] av, input logic [31:0] bv,
                                 input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                                 input bit interfere);
      int cyc;
      bus.ULAOp = 2'b10;
      bus.funct = f;
      bus.a     = av;
      bus.b     = bv;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.funct = 6'h3F;
      bus.a     = 32'h1234_5678;
      bus.b     = 32'h0000_0003;
      cyc = 1;
      check_output({tag, "_busy1"}, 64'(bus.busy), 64'd1);
      while (!bus.done && cyc < 40) begin
         if (interfere && cyc == 5) begin
            bus.start = 1'b1;
            bus.funct = 6'h19;
            bus.a     = 32'h0000_0002;
            bus.b     = 32'h0000_0002;
         end else begin
            bus.start = 1'b0;
         end
         tick();
         cyc++;
      end
      bus.start = 1'b0;
      check_output({tag, "_latency"}, 64'(cyc), 64'd33);
      check_output({tag, "_busy_done"}, 64'(bus.busy), 64'd0);
      check_output({tag, "_divzero"}, 64'(bus.div_zero), 64'd0);
      check_output({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
      check_output({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
      tick();
      check_output({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
   endtask

   initial begin
      logic [2:0] exp_sel [10];
      logic [1:0] ula_tab [10];
      logic [5:0] fun_tab [10];
      bit         saw_done;
      int         cyc;

      total = 0;
      bad   = 0;
      reset_n   = 1'b0;
      bus.ULAOp = 2'b00;
      bus.funct = 6'h00;
      bus.a     = '0;
      bus.b     = '0;
      bus.start = 1'b0;
      tick();
      tick();
      check_output("reset_busy", 64'(bus.busy), 64'd0);
      check_output("reset_done", 64'(bus.done), 64'd0);
      check_output("reset_divzero", 64'(bus.div_zero), 64'd0);
      check_output("reset_hilo", {bus.hi, bus.lo}, 64'd0);
      reset_n = 1'b1;
      tick();

      ula_tab = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
      fun_tab = '{6'h00, 6'h00, 6'h00, 6'h20, 6'h22, 6'h24, 6'h26, 6'h2A, 6'h18, 6'h3F};
      exp_sel = '{3'b001, 3'b010, 3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b111, 3'b001, 3'b001};
      for (int i = 0; i < 10; i++) begin
         bus.ULAOp = ula_tab[i];
         bus.funct = fun_tab[i];
         #1;
         check_output($sformatf("sel_%0d", i), 64'(bus.ULAOpSelector), 64'(exp_sel[i]));
      end

      apply_stimulus("mult", 6'h18, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);
      apply_stimulus("multu", 6'h19, 32'hFFFF_FFFD, 32'd7, 32'h0000_0006, 32'hFFFF_FFEB, 1'b0);
      apply_stimulus("div", 6'h1A, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      apply_stimulus("divu", 6'h1B, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
      apply_stimulus("div_ovf", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
      apply_stimulus("divu_prep", 6'h1B, 32'd68, 32'd7, 32'd5, 32'd9, 1'b0);

      bus.ULAOp = 2'b10;
      bus.funct = 6'h1B;
      bus.a     = 32'd50;
      bus.b     = 32'd0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check_output("dz_done", 64'(bus.done), 64'd1);
      check_output("dz_flag", 64'(bus.div_zero), 64'd1);
      check_output("dz_busy", 64'(bus.busy), 64'd0);
      check_output("dz_hi", 64'(bus.hi), 64'd5);
      check_output("dz_lo", 64'(bus.lo), 64'd9);
      tick();
      check_output("dz_after", {62'd0, bus.done, bus.div_zero}, 64'd0);

      bus.funct = 6'h20;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check_output("nolaunch_busy", 64'(bus.busy), 64'd0);
      check_output("nolaunch_done", 64'(bus.done), 64'd0);

      bus.funct = 6'h1B;
      bus.a     = 32'd100;
      bus.b     = 32'd7;
      bus.start = 1'b1;
      tick();
      cyc = 1;
      while (!bus.done && cyc < 40) begin
         tick();
         cyc++;
      end
      check_output("held_latency", 64'(cyc), 64'd33);
      check_output("held_lo", 64'(bus.lo), 64'd14);
      tick();
      check_output("held_relaunch_busy", 64'(bus.busy), 64'd1);
      check_output("held_relaunch_done", 64'(bus.done), 64'd0);
      bus.start = 1'b0;
      cyc = 1;
      while (!bus.done && cyc < 40) begin
         tick();
         cyc++;
      end
      check_output("held_second_latency", 64'(cyc), 64'd33);
      check_output("held_second_hi", 64'(bus.hi), 64'd2);
      tick();

      // Abort a running multiply with reset and make sure nothing completes afterwards.
      bus.funct = 6'h18;
      bus.a     = 32'd3;
      bus.b     = 32'd4;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      check_output("abort_busy_before", 64'(bus.busy), 64'd1);
      reset_n = 1'b0;
      #1;
      check_output("abort_busy", 64'(bus.busy), 64'd0);
      check_output("abort_done", 64'(bus.done), 64'd0);
      check_output("abort_hilo", {bus.hi, bus.lo}, 64'd0);
      tick();
      reset_n = 1'b1;
      saw_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.done || bus.busy) saw_done = 1'b1;
      end
      check_output("abort_no_done", 64'(saw_done), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
